// File: rtl/packet_merge_pkg.sv
// Shared types and constants for axis_packet_merge.
//   state_t      : arbiter FSM state (IDLE, GRANT0, GRANT1)
//   ADDR_*       : AXI-Lite register offsets, decoded from araddr[3:0]
//   RESP_*       : AXI-Lite read response codes
package packet_merge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_TOTAL = 4'h0;
  localparam logic [3:0] ADDR_CNT0  = 4'h4;
  localparam logic [3:0] ADDR_CNT1  = 4'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer. Registers tdata/tlast/tvalid towards
// the sink and drives s_tready from a flop, so there is no combinational
// path from m_tready back to the source. Full throughput, +1 cycle latency.
// Ports:
//   clk, resetn                  clock, async active-low reset
//   s_tdata/s_tlast/s_tvalid     upstream beat
//   s_tready                     upstream ready (registered)
//   m_tdata/m_tlast/m_tvalid     downstream beat (registered)
//   m_tready                     downstream ready
module axis_skid_buffer #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready
);

  logic                   ready_q;
  logic [TDATA_WIDTH-1:0] out_data_q;
  logic                   out_last_q;
  logic                   out_valid_q;
  logic [TDATA_WIDTH-1:0] skid_data_q;
  logic                   skid_last_q;

  assign s_tready = ready_q;
  assign m_tdata  = out_data_q;
  assign m_tlast  = out_last_q;
  assign m_tvalid = out_valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else if (ready_q) begin
      if (!out_valid_q || m_tready) begin
        // Output slot free (or draining this cycle): pass straight through.
        out_valid_q <= s_tvalid;
        out_data_q  <= s_tdata;
        out_last_q  <= s_tlast;
      end else if (s_tvalid) begin
        // Output stalled but we already advertised ready: park the beat.
        skid_data_q <= s_tdata;
        skid_last_q <= s_tlast;
        ready_q     <= 1'b0;
      end
    end else if (m_tready) begin
      // Skid entry full; it moves to the output as the old beat leaves.
      out_data_q <= skid_data_q;
      out_last_q <= skid_last_q;
      ready_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_packet_merge.sv
// Merges the two AXI-Stream outputs of packet_router (s0 = even, s1 = odd)
// into one stream. Arbitration is round-robin at packet granularity: a grant
// is held from the first beat until the tlast handshake, so packets are never
// interleaved. Per-source packet counters are readable over AXI-Lite.
// Ports:
//   clk, resetn                  clock, async active-low reset
//   s_axil_ar*/r*                read-only AXI-Lite slave
//                                (0x0 total, 0x4 cnt0, 0x8 cnt1, else SLVERR)
//   s0_axis_*, s1_axis_*         input streams
//   m_axis_*                     merged output stream
// Build option: define PACKET_MERGE_OUTPUT_REG_EN to register the output
// through axis_skid_buffer; otherwise the output is a combinational mux.
module axis_packet_merge
  import packet_merge_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [31:0]            s_axil_araddr,
  input  logic                   s_axil_arvalid,
  output logic                   s_axil_arready,
  output logic [31:0]            s_axil_rdata,
  output logic [1:0]             s_axil_rresp,
  output logic                   s_axil_rvalid,
  input  logic                   s_axil_rready,
  input  logic [TDATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                   s0_axis_tlast,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                   s1_axis_tlast,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  state_t state_q, state_next;
  logic   prio_q, prio_next;       // 0: s0 favoured, 1: s1 favoured
  logic   in_pkt_q, in_pkt_next;   // a packet is partially transferred

  // Merge point: the granted input, before the optional output register.
  logic [TDATA_WIDTH-1:0] mrg_tdata;
  logic                   mrg_tlast;
  logic                   mrg_tvalid;
  logic                   mrg_tready;
  logic                   mrg_hs;
  logic                   mrg_eop;

  logic [31:0] total_q, cnt0_q, cnt1_q;

  // ---------------------------------------------------------------------------
  // Datapath mux
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    mrg_tdata      = '0;
    mrg_tlast      = 1'b0;
    mrg_tvalid     = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      GRANT0: begin
        mrg_tdata      = s0_axis_tdata;
        mrg_tlast      = s0_axis_tlast;
        mrg_tvalid     = s0_axis_tvalid;
        s0_axis_tready = mrg_tready;
      end
      GRANT1: begin
        mrg_tdata      = s1_axis_tdata;
        mrg_tlast      = s1_axis_tlast;
        mrg_tvalid     = s1_axis_tvalid;
        s1_axis_tready = mrg_tready;
      end
      default: ;
    endcase
  end

  assign mrg_hs  = mrg_tvalid & mrg_tready;
  assign mrg_eop = mrg_hs & mrg_tlast;

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_q;
    prio_next   = prio_q;
    in_pkt_next = in_pkt_q;
    if (mrg_hs) in_pkt_next = !mrg_tlast;

    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          if (!prio_q) state_next = s0_axis_tvalid ? GRANT0 : GRANT1;
          else         state_next = s1_axis_tvalid ? GRANT1 : GRANT0;
        end
      end
      GRANT0: begin
        if (mrg_eop) begin
          prio_next = 1'b1;
          if      (s1_axis_tvalid) state_next = GRANT1;
          else if (s0_axis_tvalid) state_next = GRANT0;
          else                     state_next = IDLE;
        end else if (!in_pkt_q && !s0_axis_tvalid) begin
          // Parked on a packet boundary with nothing from s0: release the
          // grant so s1 cannot be starved by an idle s0.
          state_next = IDLE;
        end
      end
      GRANT1: begin
        if (mrg_eop) begin
          prio_next = 1'b0;
          if      (s0_axis_tvalid) state_next = GRANT0;
          else if (s1_axis_tvalid) state_next = GRANT1;
          else                     state_next = IDLE;
        end else if (!in_pkt_q && !s1_axis_tvalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_next;
      prio_q   <= prio_next;
      in_pkt_q <= in_pkt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet counters, counted at the merge input
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      total_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else if (mrg_eop) begin
      total_q <= total_q + 32'd1;
      if (state_q == GRANT0) cnt0_q <= cnt0_q + 32'd1;
      if (state_q == GRANT1) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // AXI-Lite read port
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        unused_araddr_hi;

  assign unused_araddr_hi = ^s_axil_araddr[31:4];
  assign s_axil_arready   = !s_axil_rvalid;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    case (s_axil_araddr[3:0])
      ADDR_TOTAL: begin rd_data = total_q; rd_resp = RESP_OKAY; end
      ADDR_CNT0:  begin rd_data = cnt0_q;  rd_resp = RESP_OKAY; end
      ADDR_CNT1:  begin rd_data = cnt1_q;  rd_resp = RESP_OKAY; end
      default: ;
    endcase
  end

  // NOTE: rdata/rresp are reset along with rvalid because they drive ports
  // that must read 0 out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else if (s_axil_arvalid && s_axil_arready) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_data;
      s_axil_rresp  <= rd_resp;
    end else if (s_axil_rvalid && s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef PACKET_MERGE_OUTPUT_REG_EN
  axis_skid_buffer #(
    .TDATA_WIDTH (TDATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .resetn   (resetn),
    .s_tdata  (mrg_tdata),
    .s_tlast  (mrg_tlast),
    .s_tvalid (mrg_tvalid),
    .s_tready (mrg_tready),
    .m_tdata  (m_axis_tdata),
    .m_tlast  (m_axis_tlast),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready)
  );
`else
  assign m_axis_tdata  = mrg_tdata;
  assign m_axis_tlast  = mrg_tlast;
  assign m_axis_tvalid = mrg_tvalid;
  assign mrg_tready    = m_axis_tready;
`endif

endmodule

// File: tb/tb_axis_packet_merge.sv
// Self-checking bench for axis_packet_merge. Stimulus packets are generated
// with $urandom and appended to an expected-output queue in the order the
// round-robin packet rules dictate; the collected output must equal it.
module tb_axis_packet_merge;

  localparam int W = 32;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [31:0]  s_axil_araddr = '0;
  logic         s_axil_arvalid = 1'b0;
  logic         s_axil_arready;
  logic [31:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp;
  logic         s_axil_rvalid;
  logic         s_axil_rready = 1'b0;
  logic [W-1:0] s0_axis_tdata = '0;
  logic         s0_axis_tlast = 1'b0;
  logic         s0_axis_tvalid = 1'b0;
  logic         s0_axis_tready;
  logic [W-1:0] s1_axis_tdata = '0;
  logic         s1_axis_tlast = 1'b0;
  logic         s1_axis_tvalid = 1'b0;
  logic         s1_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;

  int    checks = 0;
  int    fails  = 0;
  beat_t src0_q[$], src1_q[$], exp_q[$], got_q[$];
  int    got_cyc[$];
  bit    done;
  int    ready_mode;   // 0: always ready, 1: random, 2: one cycle in three

  axis_packet_merge #(.TDATA_WIDTH(W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Infrastructure
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    resetn = 1'b0;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    src0_q.delete(); src1_q.delete(); exp_q.delete();
    got_q.delete(); got_cyc.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Create one random packet on a source and append it to the expected
  // output; callers generate packets in the order they must appear on m.
  task automatic gen_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      if (src == 0) src0_q.push_back(b);
      else          src1_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_src(input int src, input int delay);
    beat_t b;
    bit    hs;
    repeat (delay) begin @(posedge clk); #1; end
    while (!done && ((src == 0) ? src0_q.size() : src1_q.size()) > 0) begin
      if (src == 0) begin
        b = src0_q.pop_front();
        s0_axis_tdata = b.data; s0_axis_tlast = b.last; s0_axis_tvalid = 1'b1;
      end else begin
        b = src1_q.pop_front();
        s1_axis_tdata = b.data; s1_axis_tlast = b.last; s1_axis_tvalid = 1'b1;
      end
      hs = 1'b0;
      while (!hs && !done) begin
        @(negedge clk);
        hs = (src == 0) ? s0_axis_tready : s1_axis_tready;
        @(posedge clk); #1;
      end
    end
    if (src == 0) s0_axis_tvalid = 1'b0;
    else          s1_axis_tvalid = 1'b0;
  endtask

  task automatic drive_ready();
    int k = 0;
    while (!done) begin
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 9) < 7);
        default: m_axis_tready = (k % 3 == 2);
      endcase
      k++;
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic collect(input int budget);
    int cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < budget) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back({m_axis_tlast, m_axis_tdata});
        got_cyc.push_back(cyc);
      end
      cyc++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL beat_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
    end
    done = 1'b1;
  endtask

  task automatic run_traffic(input int d0, input int d1, input int budget);
    done = 1'b0;
    fork
      drive_src(0, d0);
      drive_src(1, d1);
      drive_ready();
      collect(budget);
    join
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
    int n = 0;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    @(negedge clk);
    while (!s_axil_arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    n = 0;
    while (!s_axil_rvalid && n < 20) begin @(posedge clk); #1; n++; end
    data = s_axil_rdata;
    resp = s_axil_rresp;
    if (!s_axil_rvalid) begin
      checks++; fails++;
      $display("FAIL axil_timeout: no rvalid for addr %h", addr);
    end
    s_axil_rready = 1'b1;
    @(posedge clk); #1;
    s_axil_rready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({s_axil_arready, s_axil_rvalid, s_axil_rresp} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_axil_ctl: got ar/rv/resp=%b expected 1000",
               {s_axil_arready, s_axil_rvalid, s_axil_rresp});
    end
    checks++;
    if (s_axil_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_rdata: got %h expected 0", s_axil_rdata);
    end
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
      fails++;
      $display("FAIL reset_m_axis: got v=%b l=%b d=%h expected all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    checks++;
    if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_treadys: got %b expected 00", {s0_axis_tready, s1_axis_tready});
    end
  endtask

  task automatic test_single_packet();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] addr_t[3];
    logic [31:0] exp_t[3];
    addr_t = '{32'h0, 32'h4, 32'h8};
    exp_t  = '{32'd1, 32'd1, 32'd0};
    do_reset();
    ready_mode = 0;
    gen_pkt(0, 10);
    run_traffic(0, 0, 200);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL single_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      axil_read(addr_t[i], d, r);
      checks++;
      if (d !== exp_t[i] || r !== 2'b00) begin
        fails++;
        $display("FAIL single_reg[%h]: got %0d/%b expected %0d/00", addr_t[i], d, r, exp_t[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic [1:0]  r;
    do_reset();
    ready_mode = 0;
    gen_pkt(0, 4);   // s0 favoured after reset
    gen_pkt(1, 4);
    run_traffic(0, 0, 200);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL simul_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_cyc.size() == 8) begin
      checks++;
      if (got_cyc[4] != got_cyc[3] + 1) begin
        fails++;
        $display("FAIL simul_gap: second packet at cycle %0d, expected %0d",
                 got_cyc[4], got_cyc[3] + 1);
      end
    end
    axil_read(32'h0, d, r);
    checks++;
    if (d !== 32'd2 || r !== 2'b00) begin
      fails++; $display("FAIL simul_total: got %0d/%b expected 2/00", d, r);
    end
  endtask

  task automatic test_mid_arrival();
    do_reset();
    ready_mode = 0;
    gen_pkt(1, 5);   // s1 #1
    gen_pkt(0, 6);   // s0 arrives during s1 #1, wins the next boundary
    gen_pkt(1, 5);   // s1 #2
    gen_pkt(1, 5);   // s1 #3
    run_traffic(2, 0, 300);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL order_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_long_stall();
    bit    prev_stall;
    beat_t prev;
    do_reset();
    ready_mode = 2;
    gen_pkt(0, 321);
    prev_stall = 1'b0;
    prev = '0;
    fork
      run_traffic(0, 0, 2500);
      begin
        while (!done) begin
          @(negedge clk);
          if (prev_stall) begin
            checks++;
            if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev) begin
              fails++;
              $display("FAIL stall_hold: got v=%b %h expected v=1 %h",
                       m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev);
            end
          end
          checks++;
          if (s1_axis_tready !== 1'b0) begin
            fails++; $display("FAIL stall_s1_tready: got %b expected 0", s1_axis_tready);
          end
          prev_stall = m_axis_tvalid && !m_axis_tready;
          prev = {m_axis_tlast, m_axis_tdata};
        end
      end
    join
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL long_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_backlog();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] addr_t[3];
    logic [31:0] exp_t[3];
    addr_t = '{32'h0, 32'h4, 32'h8};
    exp_t  = '{32'd12, 32'd6, 32'd6};
    do_reset();
    ready_mode = 1;
    // Both inputs permanently backlogged: grants must strictly alternate.
    for (int p = 0; p < 6; p++) begin
      gen_pkt(0, $urandom_range(1, 8));
      gen_pkt(1, $urandom_range(1, 8));
    end
    run_traffic(0, 0, 1000);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rand_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      axil_read(addr_t[i], d, r);
      checks++;
      if (d !== exp_t[i] || r !== 2'b00) begin
        fails++;
        $display("FAIL rand_reg[%h]: got %0d/%b expected %0d/00", addr_t[i], d, r, exp_t[i]);
      end
    end
  endtask

  // Runs after test_random_backlog: total=12, cnt0=6, cnt1=6.
  task automatic test_axil();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] addr_t[4];
    logic [31:0] expd_t[4];
    logic [1:0]  expr_t[4];
    addr_t = '{32'h0000_1008, 32'hFFFF_FFF0, 32'h0000_0002, 32'h0000_0107};
    expd_t = '{32'd6, 32'd12, 32'd0, 32'd0};
    expr_t = '{2'b00, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 4; i++) begin
      axil_read(addr_t[i], d, r);
      checks++;
      if (d !== expd_t[i] || r !== expr_t[i]) begin
        fails++;
        $display("FAIL axil_decode[%h]: got %0d/%b expected %0d/%b",
                 addr_t[i], d, r, expd_t[i], expr_t[i]);
      end
    end
    // 0xC with rready held low: response must hold, arready stays low.
    s_axil_araddr = 32'hC; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axil_arready !== 1'b1) begin
      fails++; $display("FAIL axil_arready_idle: got %b expected 1", s_axil_arready);
    end
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata, s_axil_arready} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin
        fails++;
        $display("FAIL axil_hold[%0d]: got rv=%b resp=%b d=%h ar=%b expected 1/10/0/0",
                 i, s_axil_rvalid, s_axil_rresp, s_axil_rdata, s_axil_arready);
      end
      @(posedge clk); #1;
    end
    s_axil_rready = 1'b1;
    @(posedge clk); #1;
    s_axil_rready = 1'b0;
    checks++;
    if ({s_axil_rvalid, s_axil_arready} !== 2'b01) begin
      fails++;
      $display("FAIL axil_release: got rv/ar=%b expected 01", {s_axil_rvalid, s_axil_arready});
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] d;
    logic [1:0]  r;
    int          k = 0;
    int          n = 0;
    do_reset();
    m_axis_tready = 1'b1;
    s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'hA000_0000; s0_axis_tlast = 1'b0;
    while (k < 3 && n < 50) begin
      @(negedge clk);
      if (s0_axis_tready) k++;
      @(posedge clk); #1;
      s0_axis_tdata = 32'hA000_0000 + k;
      n++;
    end
    checks++;
    if (k != 3) begin
      fails++; $display("FAIL midrst_progress: got %0d beats accepted, expected 3", k);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, s0_axis_tready, s1_axis_tready, s_axil_arready} !== 4'b0001) begin
      fails++;
      $display("FAIL midrst_outputs: got mv/r0/r1/ar=%b expected 0001",
               {m_axis_tvalid, s0_axis_tready, s1_axis_tready, s_axil_arready});
    end
    s0_axis_tvalid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 3; a++) begin
      axil_read(32'(a * 4), d, r);
      checks++;
      if (d !== 32'd0 || r !== 2'b00) begin
        fails++; $display("FAIL midrst_reg[%0d]: got %0d/%b expected 0/00", a * 4, d, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_simultaneous();
    test_mid_arrival();
    test_long_stall();
    test_random_backlog();
    test_axil();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_packet_merge.md
Name:
axis_packet_merge

Overview:
Downstream recombiner for packet_router: merges its two AXI-Stream outputs (even/odd) into one stream with packet-granular round-robin arbitration, so packets are never interleaved. Keeps per-source packet counters readable over read-only AXI-Lite, using the router's register style.

Parameters:
TDATA_WIDTH, 32, width of all tdata buses.

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
s_axil_araddr  in  32  read address (byte address)
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
s0_axis_tdata  in  TDATA_WIDTH  input 0 data (router m0, even)
s0_axis_tlast  in  1  input 0 end of packet
s0_axis_tvalid  in  1  input 0 valid
s0_axis_tready  out  1  input 0 ready
s1_axis_tdata  in  TDATA_WIDTH  input 1 data (router m1, odd)
s1_axis_tlast  in  1  input 1 end of packet
s1_axis_tvalid  in  1  input 1 valid
s1_axis_tready  out  1  input 1 ready
m_axis_tdata  out  TDATA_WIDTH  merged data
m_axis_tlast  out  1  merged end of packet
m_axis_tvalid  out  1  merged valid
m_axis_tready  in  1  merged ready

Behaviour:
- Reset: all outputs 0 except s_axil_arready=1. State IDLE, priority pointer favours s0, counters 0. Reset takes effect immediately, including mid-packet. A partial packet is dropped or truncated and no count is recorded.
- FSM states: IDLE, GRANT0, GRANT1. Grant is registered.
- IDLE: if any tvalid, go to GRANT of the favoured input if it is valid, else to the valid one. This costs one bubble cycle.
- GRANTn datapath:
  - m_axis_tdata/tlast/tvalid = sn_axis_* (combinational).
  - sn_axis_tready = m_axis_tready.
  - The non-granted input's tready = 0.
  - IDLE: m_axis_tvalid = 0 and both treadys = 0.
- End of packet in GRANTn: on the tlast handshake (tvalid & tready & tlast), re-arbitrate in the same cycle, giving no bubble between packets.
  - Other input valid: go to GRANT(other).
  - Else sn tvalid: stay in GRANTn.
  - Else: go to IDLE.
  - The pointer then favours the other input.
- No upper bound on packet length. The grant is held until tlast.
- Counters: three 32-bit counters that wrap at 2^32-1.
  - total increments on any tlast handshake at the merge input.
  - cnt0 and cnt1 increment on tlast handshakes from s0 and s1 respectively.
  - All counters increment in the same cycle as the handshake.
- AXI-Lite read handshake:
  - arready = !rvalid.
  - On an ar handshake, rvalid=1 on the next cycle, with rdata and rresp registered (snapshot taken at accept).
  - rvalid, rdata and rresp are held stable until rready.
- AXI-Lite address decode (araddr[3:0]; upper bits ignored):
  - 0x0 = total, 0x4 = cnt0, 0x8 = cnt1, each with rresp=2'b00.
  - 0xC = rdata 0, rresp=2'b10 (SLVERR).
  - Unaligned addresses give rdata 0, rresp=2'b10.

Optional Feature:
PACKET_MERGE_OUTPUT_REG_EN.
- Defined: a 2-entry skid buffer registers m_axis_tdata, tlast and tvalid. The sn_axis_tready terms are driven from a register, with no combinational path from m_axis_tready. Latency is +1 cycle and full throughput is kept. Counters still count at the merge input.
- Undefined: the combinational pass-through described above.

Decomposition:
- Package packet_merge_pkg holds:
  - the state enum type;
  - ADDR_TOTAL=0x0, ADDR_CNT0=0x4, ADDR_CNT1=0x8;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Sub-module axis_skid_buffer (param TDATA_WIDTH) is instantiated only under the macro.

Test Plan:
- One 10-beat packet on s0 with m_tready=1 -> 10 beats on m with tlast on beat 10; registers read 0x0=1, 0x4=1, 0x8=0.
- s0 and s1 each raise a 4-beat packet in the same cycle after reset -> s0 packet first, then s1 with no gap and no interleaving; 0x0 reads 2.
- s1 streams 3 back-to-back 5-beat packets; a s0 packet arrives mid-s1#1 -> output order s1, s0, s1, s1.
- 321-beat s0 packet with m_tready high 1 cycle in 3 -> all data in order; m_tvalid/tdata stable while stalled; s1 tready stays 0 throughout.
- Read 0xC with rready held low 5 cycles -> rvalid=1, rdata=0, rresp=2'b10 stable all 5 cycles; arready=0 until the rready handshake.
- Assert resetn low at beat 4 of a 10-beat packet -> m_tvalid and both treadys go 0 immediately; after release, 0x0, 0x4 and 0x8 all read 0.
